// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: owns the PC, performs one memory read per fetch
// request, latches the returned word and strobes en1 when the fetch completes.
module instr_fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_fetch_pulse,
    input  logic               en_pc_pulse,
    input  logic [1:0]         pc_ctrl,
    input  logic [PC_W-1:0]    pc_target,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic               en1,
    output logic               busy,
    output logic               fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_CLEAR = 2'b11;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 fetch_err_q, fetch_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            instr_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Fetch handshake FSM; the address is captured from the pre-update PC.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        instr_d     = instr_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            ST_IDLE: begin
                if (en_fetch_pulse) begin
                    mem_addr_d = pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (en_fetch_pulse && (state_q != ST_IDLE)) begin
            fetch_err_d = 1'b1;
        end
    end

    // PC update runs independently of the fetch FSM.
    always_comb begin
        pc_d = pc_q;
        if (en_pc_pulse) begin
            case (pc_ctrl)
                PC_HOLD:  pc_d = pc_q;
                PC_INC:   pc_d = pc_q + PC_W'(1);
                PC_LOAD:  pc_d = pc_target;
                PC_CLEAR: pc_d = '0;
                default:  pc_d = pc_q;
            endcase
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign en1       = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign fetch_err = fetch_err_q;
    assign opcode    = instr_q[7:4];
    assign rd        = instr_q[3:2];
    assign rs        = instr_q[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en_fetch_pulse = 1'b0;
    logic               en_pc_pulse = 1'b0;
    logic [1:0]         pc_ctrl = 2'b00;
    logic [PC_W-1:0]    pc_target = '0;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack = 1'b0;
    logic [INSTR_W-1:0] mem_rdata = '0;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic               en1;
    logic               busy;
    logic               fetch_err;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst(rst),
        .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse),
        .pc_ctrl(pc_ctrl), .pc_target(pc_target),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .instr(instr), .opcode(opcode), .rd(rd), .rs(rs),
        .en1(en1), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an outstanding request, a completion owed next cycle,
    // the last captured address/word, the PC value and the sticky error.
    logic               m_pending = 1'b0;
    logic               m_complete = 1'b0;
    logic [PC_W-1:0]    m_pc = '0;
    logic [PC_W-1:0]    m_addr = '0;
    logic [INSTR_W-1:0] m_instr = '0;
    logic               m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic          in_flight;
        logic [PC_W-1:0] old_pc;
        if (rst) begin
            m_pending  = 1'b0;
            m_complete = 1'b0;
            m_pc       = '0;
            m_addr     = '0;
            m_instr    = '0;
            m_err      = 1'b0;
        end else begin
            in_flight  = m_pending || m_complete;
            old_pc     = m_pc;
            m_complete = 1'b0;
            if (m_pending && mem_ack) begin
                m_instr    = mem_rdata;
                m_pending  = 1'b0;
                m_complete = 1'b1;
            end
            if (en_fetch_pulse) begin
                if (in_flight) m_err = 1'b1;
                else begin
                    m_addr    = old_pc;
                    m_pending = 1'b1;
                end
            end
            if (en_pc_pulse) begin
                if (pc_ctrl == 2'd1)      m_pc = PC_W'((int'(old_pc) + 1) % (1 << PC_W));
                else if (pc_ctrl == 2'd2) m_pc = pc_target;
                else if (pc_ctrl == 2'd3) m_pc = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_req",   32'(mem_req),   32'(m_pending));
            chk("en1",       32'(en1),       32'(m_complete));
            chk("busy",      32'(busy),      32'(m_pending || m_complete));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("pc",        32'(pc),        32'(m_pc));
            chk("instr",     32'(instr),     32'(m_instr));
            chk("opcode",    32'(opcode),    32'(m_instr / 16));
            chk("rd",        32'(rd),        32'((m_instr / 4) % 4));
            chk("rs",        32'(rs),        32'(m_instr % 4));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        en_fetch_pulse = 1'b0;
        en_pc_pulse    = 1'b0;
        pc_ctrl        = 2'b00;
        mem_ack        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int n_en1;
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_en1", 32'(en1), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        @(posedge clk); #1;

        // Fetch with simultaneous PC increment, ack in cycle 1
        en_fetch_pulse = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
        tick();
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 8'h1B;
        @(negedge clk);
        chk("t1_addr", 32'(mem_addr), 32'h0);
        chk("t1_req", 32'(mem_req), 32'h1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t1_en1", 32'(en1), 32'h1);
        chk("t1_opcode", 32'(opcode), 32'h1);
        chk("t1_rd", 32'(rd), 32'h2);
        chk("t1_rs", 32'(rs), 32'h3);
        chk("t1_pc", 32'(pc), 32'h1);
        tick();

        // Ack delayed to cycle 4
        en_fetch_pulse = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mem_ack = 1'b1; mem_rdata = 8'hC4; end
            @(negedge clk);
            chk("t2_req", 32'(mem_req), 32'h1);
            chk("t2_addr", 32'(mem_addr), 32'h1);
            chk("t2_en1_low", 32'(en1), 32'h0);
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t2_en1", 32'(en1), 32'h1);
        chk("t2_instr", 32'(instr), 32'hC4);
        tick();
        @(negedge clk);
        chk("t2_en1_once", 32'(en1), 32'h0);
        tick();

        // PC wrap, load, clear
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; pc_target = 8'hFF;
        tick();
        pc_ctrl = 2'b01;
        @(negedge clk); chk("t3_pc_ff", 32'(pc), 32'hFF);
        tick();
        pc_ctrl = 2'b10; pc_target = 8'h40;
        @(negedge clk); chk("t3_wrap", 32'(pc), 32'h00);
        tick();
        pc_ctrl = 2'b11;
        @(negedge clk); chk("t3_load", 32'(pc), 32'h40);
        tick();
        pc_ctrl = 2'b00;
        @(negedge clk); chk("t3_clear", 32'(pc), 32'h00);
        tick();
        @(negedge clk); chk("t3_hold", 32'(pc), 32'h00);
        idle_inputs();
        tick();

        // Second fetch pulse while in REQ
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; pc_target = 8'h20;
        tick();
        en_fetch_pulse = 1'b1; en_pc_pulse = 1'b0;
        tick();
        en_fetch_pulse = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("t4_addr", 32'(mem_addr), 32'h20);
        chk("t4_err", 32'(fetch_err), 32'h1);
        n_en1 = 0;
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (en1) n_en1++;
            tick();
        end
        chk("t4_en1_count", 32'(n_en1), 32'h1);
        chk("t4_err_sticky", 32'(fetch_err), 32'h1);

        // Reset in the middle of REQ
        en_fetch_pulse = 1'b1;
        tick();
        en_fetch_pulse = 1'b0;
        @(negedge clk);
        chk("t5_req_before", 32'(mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_async", 32'(mem_req), 32'h0);
        chk("t5_pc", 32'(pc), 32'h0);
        chk("t5_instr", 32'(instr), 32'h0);
        chk("t5_addr", 32'(mem_addr), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_err", 32'(fetch_err), 32'h0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t5_instr_after", 32'(instr), 32'h0);
        chk("t5_en1_after", 32'(en1), 32'h0);
        tick();

        // Stray ack in IDLE
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t6_instr", 32'(instr), 32'h0);
        chk("t6_en1", 32'(en1), 32'h0);
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            en_fetch_pulse = ($urandom_range(0, 3) == 0);
            en_pc_pulse    = ($urandom_range(0, 2) == 0);
            pc_ctrl        = 2'($urandom_range(0, 3));
            pc_target      = PC_W'($urandom);
            mem_ack        = ($urandom_range(0, 2) == 0);
            mem_rdata      = INSTR_W'($urandom);
            if (i % 500 == 250) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        idle_inputs();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
